// File: rtl/tlp_req_player_if.sv
// Command, TLP lane, completion and status signals of the TLP request player.
// master: the player itself; slave: the host/bench side that feeds commands
// and returns completions.
interface tlp_req_player_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;

    logic        tl_rx_sop;
    logic        tl_rx_eop;
    logic [31:0] data_7;
    logic [31:0] data_6;
    logic [31:0] data_5;
    logic [31:0] data_4;
    logic [31:0] data_3;
    logic [31:0] data_2;
    logic [31:0] data_1;
    logic [31:0] data_0;

    logic        cpl_valid;
    logic [7:0]  cpl_tag;
    logic [31:0] cpl_data;

    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_timeout;
    logic [7:0]  stray_cnt;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data,
        input  cpl_valid, cpl_tag, cpl_data,
        output cmd_ready,
        output tl_rx_sop, tl_rx_eop,
        output data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0,
        output rd_valid, rd_data, rd_timeout, stray_cnt, busy
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data,
        output cpl_valid, cpl_tag, cpl_data,
        input  cmd_ready,
        input  tl_rx_sop, tl_rx_eop,
        input  data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0,
        input  rd_valid, rd_data, rd_timeout, stray_cnt, busy
    );
endinterface

// File: rtl/tlp_req_player.sv
// TLP request player: buffers register write/read commands in a small FIFO
// and plays each one as a single-beat TLP on the 256-bit RX lane bus. Reads
// wait for a tag-matched completion (or time out); every TLP is followed by
// a fixed idle gap. Unmatched completions are counted and dropped.
module tlp_req_player #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 10,
    parameter int TAG_BITS   = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic             tlp_clk,
    input  logic             rst,
    tlp_req_player_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // command FIFO
    logic [64:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // engine
    logic [1:0]          state;
    logic [TAG_BITS-1:0] tag;
    logic [TW-1:0]       timer;
    logic [GW-1:0]       gap_cnt;

    // command being played (data path, not reset)
    logic                hold_wr;
    logic [31:0]         hold_addr;
    logic [31:0]         hold_data;
    logic [TAG_BITS-1:0] hold_tag;

    logic        rd_valid_r;
    logic        rd_timeout_r;
    logic [31:0] rd_data_r;
    logic [7:0]  stray_r;

    logic send;
    logic cpl_match;
    logic stray;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // full is decided before any same-cycle pop: no push while full
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state == S_IDLE) && !empty;

    assign send      = (state == S_SEND);
    assign cpl_match = (state == S_WAIT) && bus.cpl_valid && (bus.cpl_tag == 8'(hold_tag));
    assign stray     = bus.cpl_valid && !cpl_match;

    // FIFO storage: written on accept, no reset needed
    always_ff @(posedge tlp_clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_wr, bus.cmd_addr, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge tlp_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // latch the popped command and the tag it will carry
    always_ff @(posedge tlp_clk) begin
        if (pop) begin
            {hold_wr, hold_addr, hold_data} <= mem[rd_ptr];
            hold_tag                        <= tag;
        end
    end

    // engine FSM: send, wait for completion or timeout, idle gap
    always_ff @(posedge tlp_clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tag          <= '0;
            timer        <= '0;
            gap_cnt      <= '0;
            rd_valid_r   <= 1'b0;
            rd_timeout_r <= 1'b0;
            rd_data_r    <= '0;
            stray_r      <= '0;
        end else begin
            rd_valid_r   <= 1'b0;
            rd_timeout_r <= 1'b0;
            if (stray && (stray_r != 8'hFF)) begin
                stray_r <= stray_r + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!empty) state <= S_SEND;
                end
                S_SEND: begin
                    tag     <= tag + 1'b1;
                    timer   <= '0;
                    gap_cnt <= '0;
                    state   <= hold_wr ? S_GAP : S_WAIT;
                end
                S_WAIT: begin
                    // a match on the last allowed cycle still wins over timeout
                    if (cpl_match) begin
                        rd_data_r  <= bus.cpl_data;
                        rd_valid_r <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end else if (timer == TMO_LAST) begin
                        rd_timeout_r <= 1'b1;
                        gap_cnt      <= '0;
                        state        <= S_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (gap_cnt == GAP_LAST) state <= S_IDLE;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.tl_rx_sop  = send;
    assign bus.tl_rx_eop  = send;
    assign bus.data_7     = (send && hold_wr) ? 32'h4000_0000 : 32'h0;
    assign bus.data_6     = send ? {16'h0, 8'(hold_tag), 8'h0F} : 32'h0;
    assign bus.data_5     = send ? hold_addr : 32'h0;
    assign bus.data_4     = (send && hold_wr) ? hold_data : 32'h0;
    assign bus.data_3     = 32'h0;
    assign bus.data_2     = 32'h0;
    assign bus.data_1     = 32'h0;
    assign bus.data_0     = 32'h0;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.rd_timeout = rd_timeout_r;
    assign bus.stray_cnt  = stray_r;
    assign bus.busy       = (state != S_IDLE) || !empty;
endmodule

// File: tb/tb_tlp_req_player.sv
// Bench for tlp_req_player: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a transaction-level model.
module tb_tlp_req_player;
    localparam int FIFO_DEPTH = 8;
    localparam int GAP_CYCLES = 10;
    localparam int TAG_BITS   = 3;
    localparam int TIMEOUT    = 1023;

    logic tlp_clk = 1'b0;
    logic rst     = 1'b1;

    tlp_req_player_if ifc();

    tlp_req_player #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .GAP_CYCLES(GAP_CYCLES),
        .TAG_BITS  (TAG_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .tlp_clk(tlp_clk),
        .rst    (rst),
        .bus    (ifc)
    );

    always #5 tlp_clk = ~tlp_clk;

    int n_total = 0;
    int n_bad   = 0;

    function automatic void chk256(string name, logic [255:0] act, logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; int acc; } cmd_t;
    typedef struct { int cyc; logic [31:0] d7; logic [31:0] d6; logic [31:0] d5; logic [31:0] d4; } beat_t;
    typedef struct { int cyc; logic [31:0] data; } rdv_t;

    // observed events
    beat_t sop_log[$];
    rdv_t  rdv_log[$];
    int    rdt_log[$];

    // model state: commands in the FIFO, the command about to be sent,
    // the outstanding read, and the earliest cycle a new command may be popped
    cmd_t        q[$];
    cmd_t        sp;
    bit          sp_v     = 1'b0;
    int          sp_cyc   = 0;
    logic [7:0]  sp_tag   = 8'h0;
    bit          pr_v     = 1'b0;
    logic [7:0]  pr_tag   = 8'h0;
    int          pr_dead  = 0;
    int          rdv_at   = -1;
    int          rdt_at   = -1;
    int          busy_end = -1;
    int          f_cyc    = 0;
    int          tagm     = 0;
    int          exp_stray = 0;
    logic [31:0] exp_rd_data = 32'h0;
    int          mcyc = 0;

    // engine becomes free GAP cycles after the resolving cycle r, pops on the next one
    function automatic void resolve(int r);
        busy_end = r + GAP_CYCLES;
        f_cyc    = r + GAP_CYCLES + 1;
    endfunction

    task automatic model_cycle();
        logic [255:0] act_lanes;
        logic [255:0] exp_lanes;
        bit    ready_now;
        bit    exp_sop;
        bit    exp_busy;
        beat_t b;
        rdv_t  rv;
        cmd_t  c;
        act_lanes = {ifc.data_7, ifc.data_6, ifc.data_5, ifc.data_4,
                     ifc.data_3, ifc.data_2, ifc.data_1, ifc.data_0};
        if (ifc.tl_rx_sop) begin
            b.cyc = mcyc; b.d7 = ifc.data_7; b.d6 = ifc.data_6; b.d5 = ifc.data_5; b.d4 = ifc.data_4;
            sop_log.push_back(b);
        end
        if (ifc.rd_valid) begin
            rv.cyc = mcyc; rv.data = ifc.rd_data;
            rdv_log.push_back(rv);
        end
        if (ifc.rd_timeout) rdt_log.push_back(mcyc);

        if (rst) begin
            chk32("rst_ctrl", 32'({ifc.tl_rx_sop, ifc.tl_rx_eop, ifc.rd_valid, ifc.rd_timeout,
                                   ifc.busy, ifc.cmd_ready}), 32'h1);
            chk256("rst_lanes", act_lanes, 256'h0);
            chk32("rst_rd_data", ifc.rd_data, 32'h0);
            chk32("rst_stray", 32'(ifc.stray_cnt), 32'h0);
            q.delete();
            sp_v = 1'b0; pr_v = 1'b0; rdv_at = -1; rdt_at = -1;
            busy_end = -1; f_cyc = 0; tagm = 0; exp_stray = 0; exp_rd_data = 32'h0;
            return;
        end

        ready_now = (q.size() < FIFO_DEPTH);
        exp_sop   = sp_v && (sp_cyc == mcyc);
        exp_lanes = '0;
        if (exp_sop) begin
            exp_lanes[255:128] = {sp.wr ? 32'h4000_0000 : 32'h0,
                                  {16'h0, sp_tag, 8'h0F},
                                  sp.addr,
                                  sp.wr ? sp.data : 32'h0};
        end
        exp_busy = (q.size() > 0) || sp_v || pr_v || (mcyc <= busy_end);

        chk32("sop", 32'(ifc.tl_rx_sop), 32'(exp_sop));
        chk32("eop", 32'(ifc.tl_rx_eop), 32'(exp_sop));
        chk256("lanes", act_lanes, exp_lanes);
        chk32("rd_valid", 32'(ifc.rd_valid), 32'(rdv_at == mcyc));
        chk32("rd_timeout", 32'(ifc.rd_timeout), 32'(rdt_at == mcyc));
        chk32("rd_data", ifc.rd_data, exp_rd_data);
        chk32("stray_cnt", 32'(ifc.stray_cnt), 32'(exp_stray));
        chk32("cmd_ready", 32'(ifc.cmd_ready), 32'(ready_now));
        chk32("busy", 32'(ifc.busy), 32'(exp_busy));

        // completions: only a tag match on an outstanding read counts
        if (ifc.cpl_valid) begin
            if (pr_v && (ifc.cpl_tag == pr_tag)) begin
                exp_rd_data = ifc.cpl_data;
                rdv_at      = mcyc + 1;
                pr_v        = 1'b0;
                resolve(mcyc);
            end else if (exp_stray < 255) begin
                exp_stray++;
            end
        end
        if (pr_v && (mcyc == pr_dead)) begin
            rdt_at = mcyc + 1;
            pr_v   = 1'b0;
            resolve(mcyc);
        end
        if (sp_v && (sp_cyc == mcyc)) begin
            sp_v = 1'b0;
            if (sp.wr) begin
                resolve(mcyc);
            end else begin
                pr_v    = 1'b1;
                pr_tag  = sp_tag;
                pr_dead = mcyc + TIMEOUT;
            end
            tagm = (tagm + 1) % (1 << TAG_BITS);
        end
        if (!sp_v && !pr_v && (mcyc >= f_cyc) && (q.size() > 0)) begin
            if (mcyc >= q[0].acc + 1) begin
                sp     = q.pop_front();
                sp_v   = 1'b1;
                sp_cyc = mcyc + 1;
                sp_tag = 8'(tagm);
            end
        end
        if (ifc.cmd_valid && ready_now) begin
            c.wr = ifc.cmd_wr; c.addr = ifc.cmd_addr; c.data = ifc.cmd_data; c.acc = mcyc;
            q.push_back(c);
        end
    endtask

    initial begin
        forever begin
            @(negedge tlp_clk);
            model_cycle();
            mcyc++;
        end
    end

    // completion responder; mode 0 silent, 1 random, 2 stray then match,
    // 4 single stray, 5 stray every cycle
    int          resp_mode   = 0;
    int          c_good      = 0;
    int          c_bad       = 0;
    int          noreply_cnt = 0;
    logic [7:0]  r_tag       = 8'h0;
    logic [31:0] r_data      = 32'h0;

    initial begin
        int r;
        int d;
        ifc.cpl_valid = 1'b0;
        ifc.cpl_tag   = 8'h0;
        ifc.cpl_data  = 32'h0;
        forever begin
            @(posedge tlp_clk);
            #2;
            ifc.cpl_valid = 1'b0;
            if (rst) begin
                c_good = 0;
                c_bad  = 0;
            end else begin
                if (c_good > 0) begin
                    c_good--;
                    if (c_good == 0) begin
                        ifc.cpl_valid = 1'b1; ifc.cpl_tag = r_tag; ifc.cpl_data = r_data;
                    end
                end
                if (c_bad > 0) begin
                    c_bad--;
                    if (c_bad == 0 && !ifc.cpl_valid) begin
                        ifc.cpl_valid = 1'b1; ifc.cpl_tag = r_tag + 8'd1; ifc.cpl_data = 32'hDEAD;
                    end
                end
                if (resp_mode == 1 && !ifc.cpl_valid && $urandom_range(0, 99) < 2) begin
                    ifc.cpl_valid = 1'b1; ifc.cpl_tag = 8'($urandom); ifc.cpl_data = $urandom;
                end
                if (resp_mode == 5) begin
                    ifc.cpl_valid = 1'b1; ifc.cpl_tag = 8'hFF; ifc.cpl_data = 32'h1;
                end
                if (ifc.tl_rx_sop && ifc.data_7 == 32'h0) begin
                    r_tag = ifc.data_6[15:8];
                    case (resp_mode)
                        1: begin
                            r      = $urandom_range(0, 99);
                            d      = $urandom_range(2, 30);
                            r_data = $urandom;
                            if (r < 8 && noreply_cnt < 2) begin
                                noreply_cnt++;
                            end else begin
                                c_good = d;
                                if (r < 30) c_bad = $urandom_range(1, d - 1);
                            end
                        end
                        2: begin c_bad = 2; c_good = 5; r_data = 32'h0000_A5A5; end
                        4: c_bad = 1;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge tlp_clk); #1; end
    endtask

    task automatic push(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int k;
        bit done;
        k = 0; done = 1'b0;
        ifc.cmd_valid = 1'b1; ifc.cmd_wr = wr; ifc.cmd_addr = a; ifc.cmd_data = d;
        while (!done && k < 3000) begin
            @(negedge tlp_clk);
            done = ifc.cmd_ready;
            @(posedge tlp_clk);
            #1;
            k++;
        end
        ifc.cmd_valid = 1'b0;
        if (!done) chk32("push_budget", 32'(k), 32'(0));
    endtask

    function automatic int log_size(int kind);
        if (kind == 0) return sop_log.size();
        if (kind == 1) return rdv_log.size();
        return rdt_log.size();
    endfunction

    task automatic wait_log(int kind, int n, int budget);
        int k;
        k = 0;
        while (log_size(kind) < n && k < budget) begin
            tick(1);
            k++;
        end
        if (log_size(kind) < n) chk32("wait_budget", 32'(log_size(kind)), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        resp_mode = 0;
        tick(2);
        rst = 1'b0;
        sop_log.delete(); rdv_log.delete(); rdt_log.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.cmd_valid = 1'b0; ifc.cmd_wr = 1'b0; ifc.cmd_addr = 32'h0; ifc.cmd_data = 32'h0;
        tick(3);
        chk32("reset_cmd_ready", 32'(ifc.cmd_ready), 32'h1);
        chk32("reset_busy", 32'(ifc.busy), 32'h0);
        chk32("reset_sop", 32'(ifc.tl_rx_sop), 32'h0);
        chk32("reset_rd_data", ifc.rd_data, 32'h0);
        rst = 1'b0;
        tick(2);

        // single write
        push(1'b1, 32'hF800, 32'h2);
        wait_log(0, 1, 20);
        if (sop_log.size() >= 1) begin
            chk32("t1_d7", sop_log[0].d7, 32'h4000_0000);
            chk32("t1_d6", sop_log[0].d6, 32'h0000_000F);
            chk32("t1_d5", sop_log[0].d5, 32'h0000_F800);
            chk32("t1_d4", sop_log[0].d4, 32'h0000_0002);
        end
        tick(15);

        // three back-to-back writes
        do_reset();
        push(1'b1, 32'h10, 32'h1);
        push(1'b1, 32'h14, 32'h2);
        push(1'b1, 32'h18, 32'h3);
        wait_log(0, 3, 100);
        if (sop_log.size() >= 3) begin
            chk32("t2_gap01", 32'(sop_log[1].cyc - sop_log[0].cyc), 32'd12);
            chk32("t2_gap12", 32'(sop_log[2].cyc - sop_log[1].cyc), 32'd12);
            for (int i = 0; i < 3; i++) chk32("t2_tag", 32'(sop_log[i].d6[15:8]), 32'(i));
        end
        tick(15);

        // read with a stray completion before the matching one
        do_reset();
        resp_mode = 2;
        push(1'b0, 32'hF800, 32'h0);
        wait_log(1, 1, 100);
        if (rdv_log.size() >= 1 && sop_log.size() >= 1) begin
            chk32("t3_rd_data", rdv_log[0].data, 32'h0000_A5A5);
            chk32("t3_latency", 32'(rdv_log[0].cyc - sop_log[0].cyc), 32'd6);
            chk32("t3_tag", 32'(sop_log[0].d6[15:8]), 32'h0);
        end
        chk32("t3_stray", 32'(ifc.stray_cnt), 32'd1);
        tick(15);

        // read that times out, followed by a queued write
        do_reset();
        push(1'b0, 32'h100, 32'h0);
        push(1'b1, 32'h200, 32'h55);
        wait_log(2, 1, 1200);
        wait_log(0, 2, 100);
        if (rdt_log.size() >= 1 && sop_log.size() >= 2) begin
            chk32("t4_timeout_at", 32'(rdt_log[0] - sop_log[0].cyc), 32'd1024);
            chk32("t4_next_send", 32'(sop_log[1].cyc - sop_log[0].cyc), 32'd1035);
            chk32("t4_next_d7", sop_log[1].d7, 32'h4000_0000);
            chk32("t4_next_tag", 32'(sop_log[1].d6[15:8]), 32'd1);
        end
        chk32("t4_no_rd_valid", 32'(rdv_log.size()), 32'd0);
        tick(15);

        // FIFO fills behind a stalled read; tags wrap
        do_reset();
        push(1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 8; i++) push(1'b1, 32'h400 + 32'(4 * i), 32'(i));
        chk32("t5_ready_full", 32'(ifc.cmd_ready), 32'h0);
        push(1'b1, 32'h420, 32'h8);
        wait_log(0, 10, 2000);
        if (sop_log.size() >= 10) begin
            chk32("t5_addr0", sop_log[0].d5, 32'h300);
            for (int i = 0; i < 10; i++) begin
                chk32("t5_tag", 32'(sop_log[i].d6[15:8]), 32'(i % 8));
                if (i > 0) chk32("t5_addr", sop_log[i].d5, 32'h400 + 32'(4 * (i - 1)));
            end
        end
        tick(15);

        // reset during completion wait
        do_reset();
        resp_mode = 4;
        push(1'b0, 32'h500, 32'h0);
        wait_log(0, 1, 20);
        tick(4);
        chk32("t6_stray_before", 32'(ifc.stray_cnt), 32'd1);
        chk32("t6_busy_before", 32'(ifc.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk32("t6_busy", 32'(ifc.busy), 32'h0);
        chk32("t6_stray", 32'(ifc.stray_cnt), 32'h0);
        chk32("t6_ready", 32'(ifc.cmd_ready), 32'h1);
        chk32("t6_sop", 32'(ifc.tl_rx_sop), 32'h0);
        do_reset();
        push(1'b1, 32'h600, 32'h7);
        wait_log(0, 1, 20);
        if (sop_log.size() >= 1) begin
            chk32("t6_tag", 32'(sop_log[0].d6[15:8]), 32'h0);
            chk32("t6_addr", sop_log[0].d5, 32'h600);
        end
        tick(15);

        // randomized traffic
        do_reset();
        resp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            tick($urandom_range(0, 4));
            push(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
        end
        begin
            int k;
            k = 0;
            while ((ifc.busy || c_good > 0 || c_bad > 0) && k < 5000) begin
                tick(1);
                k++;
            end
            if (k >= 5000) chk32("drain_budget", 32'(k), 32'd0);
        end
        tick(5);

        // stray counter saturation
        resp_mode = 5;
        tick(300);
        resp_mode = 0;
        tick(3);
        chk32("stray_saturate", 32'(ifc.stray_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
